prefix_engine: RTL and testbench

Parametrised expression engine for the arithmetic datapath. It accepts a variable-length token stream and runs in one of two modes. Mode 0 evaluates a prefix expression to a signed result. Mode 1 converts an infix expression with parentheses into a packed postfix token string. Compared with the fixed-length generation, it adds variable length, configurable depth and width, parentheses support and an error flag.

---
 rtl/prefix_engine.sv | 222 ++++++++++++++++++++++
 tb/tb_prefix_engine.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefix_engine.sv
// prefix_engine: token-stream expression engine.
// Mode 0 evaluates a prefix expression to a signed ACC_W result; mode 1
// converts an infix expression (with parentheses) to packed postfix tokens.
module prefix_engine #(
  parameter int MAX_TOK = 19,
  parameter int ACC_W   = 40,
  parameter int OUT_W   = 95
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         opt,
  input  logic [4:0]                   in_data,
  output logic                         out_valid,
  output logic [OUT_W-1:0]             out,
  output logic [$clog2(MAX_TOK+1)-1:0] out_len,
  output logic                         err
);
  localparam int LW = $clog2(MAX_TOK+1);
  localparam logic [LW-1:0] MAXL = LW'(MAX_TOK);

  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, EVAL = 3'd2,
                         CONV = 3'd3, FLUSH = 3'd4, DONE = 3'd5;

  localparam logic [4:0] T_ADD = 5'd16, T_SUB = 5'd17, T_MUL = 5'd18,
                         T_DIV = 5'd19, T_LP = 5'd20, T_RP = 5'd21;

  logic [2:0]                    state;
  logic                          mode, sticky_err;
  logic [LW-1:0]                 len, cnt, sp, olen;
  logic [OUT_W-1:0]              obuf;
  logic [MAX_TOK-1:0][4:0]       tbuf, cst;
  logic [MAX_TOK-1:0][ACC_W-1:0] est;

  logic [LW-1:0]           tidx, top_i, nxt_i, sp_n, olen_n;
  logic [4:0]              tok, ctop, app_tok;
  logic signed [ACC_W-1:0] opa, opb, e_val;
  logic [OUT_W-1:0]        obuf_n, e_ext;
  logic                    step_err, advance, push_e, push_c, app;
  logic                    last, fin, fin_err;

  // EVAL walks the buffer back to front, CONV front to back; one shared
  // stack pointer serves whichever stack the current mode uses.
  assign tidx  = (state == EVAL) ? len - 1'b1 - cnt : cnt;
  assign top_i = (sp == '0) ? '0 : sp - 1'b1;
  assign nxt_i = (sp < LW'(2)) ? '0 : sp - LW'(2);
  assign tok   = tbuf[tidx];
  assign ctop  = cst[top_i];
  assign opa   = est[top_i];
  assign opb   = est[nxt_i];
  assign last  = (cnt == len - 1'b1);
  assign e_ext = OUT_W'(e_val);

  // One processing step: decide push/pop/append and any error for this cycle.
  always_comb begin
    step_err = 1'b0;
    advance  = 1'b0;
    push_e   = 1'b0;
    push_c   = 1'b0;
    app      = 1'b0;
    app_tok  = tok;
    sp_n     = sp;
    e_val    = '0;
    case (state)
      EVAL: begin
        advance = 1'b1;
        if (!tok[4]) begin
          e_val  = ACC_W'(tok[3:0]);
          push_e = 1'b1;
          sp_n   = sp + 1'b1;
        end else if (tok > T_DIV || sp < LW'(2)) begin
          step_err = 1'b1;
        end else if (tok == T_DIV && opb == '0) begin
          step_err = 1'b1;
        end else begin
          push_e = 1'b1;
          sp_n   = sp - 1'b1;
          case (tok)
            T_ADD:   e_val = opa + opb;
            T_SUB:   e_val = opa - opb;
            T_MUL:   e_val = opa * opb;
            default: e_val = opa / opb;
          endcase
        end
      end
      CONV: begin
        if (!tok[4]) begin
          app     = 1'b1;
          advance = 1'b1;
        end else if (tok > T_RP) begin
          step_err = 1'b1;
          advance  = 1'b1;
        end else if (tok == T_LP) begin
          push_c  = 1'b1;
          sp_n    = sp + 1'b1;
          advance = 1'b1;
        end else if (tok == T_RP) begin
          if (sp == '0) begin
            step_err = 1'b1;
            advance  = 1'b1;
          end else if (ctop == T_LP) begin
            sp_n    = sp - 1'b1;
            advance = 1'b1;
          end else begin
            app     = 1'b1;
            app_tok = ctop;
            sp_n    = sp - 1'b1;
          end
        end else if (sp != '0 && ctop != T_LP && ctop[1] >= tok[1]) begin
          // bit1 separates '*' '/' from '+' '-': higher or equal precedence pops
          app     = 1'b1;
          app_tok = ctop;
          sp_n    = sp - 1'b1;
        end else begin
          push_c  = 1'b1;
          sp_n    = sp + 1'b1;
          advance = 1'b1;
        end
      end
      FLUSH: begin
        sp_n = sp - 1'b1;
        if (ctop == T_LP) step_err = 1'b1;
        else begin
          app     = 1'b1;
          app_tok = ctop;
        end
      end
      default: ;
    endcase
  end

  // Postfix output buffer with this cycle's append folded in.
  always_comb begin
    obuf_n = obuf;
    olen_n = olen;
    if (app) begin
      obuf_n = obuf | (OUT_W'(app_tok) << (OUT_W - 5 - 5 * int'(olen)));
      olen_n = olen + 1'b1;
    end
  end

  // Final-step detection; outputs register on the edge that ends the last step.
  always_comb begin
    fin = 1'b0;
    if (state == EVAL)       fin = last;
    else if (state == CONV)  fin = advance && last && (sp_n == '0);
    else if (state == FLUSH) fin = (sp == LW'(1));
    fin_err = sticky_err | step_err | ((state == EVAL) && (sp_n != LW'(1)));
  end

  // Token buffer and stack storage; contents are qualified by len/sp.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == IDLE && in_valid) tbuf[0] <= in_data;
      if (state == LOAD && in_valid && len != MAXL) tbuf[len] <= in_data;
      if (push_e) est[sp_n - 1'b1] <= e_val;
      if (push_c) cst[sp] <= tok;
    end
  end

  // Control FSM, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode       <= 1'b0;
      len        <= '0;
      cnt        <= '0;
      sp         <= '0;
      olen       <= '0;
      obuf       <= '0;
      sticky_err <= 1'b0;
      out_valid  <= 1'b0;
      out        <= '0;
      out_len    <= '0;
      err        <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out       <= '0;
      out_len   <= '0;
      err       <= 1'b0;
      sp        <= sp_n;
      obuf      <= obuf_n;
      olen      <= olen_n;
      if (advance)  cnt <= cnt + 1'b1;
      if (step_err) sticky_err <= 1'b1;
      case (state)
        IDLE: if (in_valid) begin
          len        <= LW'(1);
          mode       <= opt;
          cnt        <= '0;
          sp         <= '0;
          olen       <= '0;
          obuf       <= '0;
          sticky_err <= 1'b0;
          state      <= LOAD;
        end
        LOAD: begin
          if (in_valid) begin
            if (len == MAXL) sticky_err <= 1'b1;
            else             len <= len + 1'b1;
          end else begin
            state <= mode ? CONV : EVAL;
          end
        end
        EVAL, CONV, FLUSH: begin
          if (fin) begin
            out_valid <= 1'b1;
            err       <= fin_err;
            out       <= fin_err ? '0 : ((state == EVAL) ? e_ext : obuf_n);
            out_len   <= (fin_err || state == EVAL) ? '0 : olen_n;
            state     <= DONE;
          end else if (state == CONV && advance && last) begin
            state <= FLUSH;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prefix_engine.sv
// tb_prefix_engine: random and directed jobs against a queue-based model.
module tb_prefix_engine;
  localparam int MT  = 19;
  localparam int AW  = 40;
  localparam int OW  = 95;
  localparam int LW  = $clog2(MT+1);

  logic          clk = 1'b0;
  logic          rst, in_valid, opt;
  logic [4:0]    in_data;
  logic          out_valid, err;
  logic [OW-1:0] dout;
  logic [LW-1:0] out_len;

  int n_chk = 0;
  int n_err = 0;

  logic [4:0]    tq[$];
  logic [OW-1:0] m_out, o_out;
  int            m_len, m_lat;
  bit            m_err;
  logic [LW-1:0] o_len;
  logic          o_err;

  prefix_engine #(.MAX_TOK(MT), .ACC_W(AW), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opt(opt), .in_data(in_data),
    .out_valid(out_valid), .out(dout), .out_len(out_len), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint wrap(input longint x);
    logic signed [AW-1:0] t;
    t = x[AW-1:0];
    return longint'(t);
  endfunction

  function automatic int prec(input logic [4:0] t);
    return (t == 5'd18 || t == 5'd19) ? 2 : 1;
  endfunction

  // Prefix evaluation: scan right to left with a value stack.
  task automatic model0();
    longint st[$];
    longint a, b, r;
    logic signed [OW-1:0] s;
    int n, t;
    bit e;
    n = (tq.size() > MT) ? MT : tq.size();
    e = (tq.size() > MT);
    for (int i = n - 1; i >= 0 && !e; i--) begin
      t = int'(tq[i]);
      r = 0;
      if (t < 16) st.push_back(longint'(t));
      else if (t > 19 || st.size() < 2) e = 1;
      else begin
        a = st.pop_back();
        b = st.pop_back();
        case (t)
          16: r = a + b;
          17: r = a - b;
          18: r = a * b;
          default: if (b == 0) e = 1; else r = a / b;
        endcase
        st.push_back(wrap(r));
      end
    end
    if (!e && st.size() != 1) e = 1;
    m_err = e;
    m_len = 0;
    m_lat = n + 1;
    m_out = '0;
    if (!e) begin
      s = st[0];
      m_out = s;
    end
  endtask

  // Shunting-yard conversion, counting every stack pop that emits or checks a token.
  task automatic model1();
    logic [4:0] st[$];
    logic [4:0] oq[$];
    logic [4:0] t;
    int n, p;
    bit e;
    n = (tq.size() > MT) ? MT : tq.size();
    e = (tq.size() > MT);
    p = 0;
    for (int i = 0; i < n; i++) begin
      t = tq[i];
      if (t < 16) oq.push_back(t);
      else if (t > 21) e = 1;
      else if (t == 20) st.push_back(t);
      else if (t == 21) begin
        while (st.size() > 0 && st[$] != 5'd20) begin oq.push_back(st.pop_back()); p++; end
        if (st.size() == 0) e = 1; else void'(st.pop_back());
      end else begin
        while (st.size() > 0 && st[$] != 5'd20 && prec(st[$]) >= prec(t)) begin
          oq.push_back(st.pop_back());
          p++;
        end
        st.push_back(t);
      end
    end
    while (st.size() > 0) begin
      t = st.pop_back();
      p++;
      if (t == 20) e = 1; else oq.push_back(t);
    end
    m_err = e;
    m_lat = n + p + 1;
    m_out = '0;
    m_len = 0;
    if (!e) begin
      m_len = oq.size();
      foreach (oq[k]) m_out = m_out | (OW'(oq[k]) << (OW - 5 - 5 * k));
    end
  endtask

  task automatic gen_prefix(input int k);
    int need, ops;
    need = 1;
    ops  = k;
    tq.delete();
    while (need > 0) begin
      if (ops > 0 && (need == 1 || $urandom_range(1, 0) == 1)) begin
        tq.push_back(5'(16 + $urandom_range(3, 0)));
        ops--;
        need++;
      end else begin
        tq.push_back(5'($urandom_range(15, 0)));
        need--;
      end
    end
  endtask

  task automatic gen_infix();
    int depth;
    bit want, go;
    depth = 0; want = 1; go = 1;
    tq.delete();
    while (go) begin
      if (want) begin
        if (tq.size() + depth + 5 < MT && $urandom_range(3, 0) == 0) begin
          tq.push_back(5'd20); depth++;
        end else begin
          tq.push_back(5'($urandom_range(15, 0))); want = 0;
        end
      end else if (depth > 0 && $urandom_range(2, 0) == 0) begin
        tq.push_back(5'd21); depth--;
      end else if (tq.size() + depth + 3 < MT && $urandom_range(3, 0) != 0) begin
        tq.push_back(5'(16 + $urandom_range(3, 0))); want = 1;
      end else if (depth > 0) begin
        tq.push_back(5'd21); depth--;
      end else go = 0;
    end
  endtask

  task automatic gen_junk();
    tq.delete();
    repeat ($urandom_range(12, 1)) tq.push_back(5'($urandom_range(23, 0)));
  endtask

  // Drive tq as one job and check the result against the model.
  task automatic do_job(input bit m, input bit tog, input string tag);
    int lat, nst;
    bit bad, pbad;
    if (m) model1(); else model0();
    nst = (tq.size() > MT) ? MT : tq.size();
    foreach (tq[i]) begin
      in_valid = 1'b1;
      in_data  = tq[i];
      opt      = (i == 0) ? m : 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    lat = 0; bad = 0; pbad = 0;
    for (int c = 1; c <= 4 * MT + 8; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        if (lat == 0) begin
          lat = c; o_out = dout; o_len = out_len; o_err = err;
        end else pbad = 1;
      end else if (dout != '0 || out_len != '0 || err) bad = 1;
      in_valid = (tog && c <= nst) ? 1'($urandom) : 1'b0;
      in_data  = 5'($urandom);
      opt      = 1'($urandom);
      if (lat != 0 && c > lat) break;
    end
    in_valid = 1'b0;
    chk({tag, ":seen"}, 128'(lat != 0), 128'(1));
    if (!m || !m_err) chk({tag, ":lat"}, 128'(lat), 128'(m_lat));
    chk({tag, ":out"}, 128'(o_out), 128'(m_out));
    chk({tag, ":len"}, 128'(o_len), 128'(m_len));
    chk({tag, ":err"}, 128'(o_err), 128'(m_err));
    chk({tag, ":quiet"}, 128'(bad), 128'(0));
    chk({tag, ":pulse"}, 128'(pbad), 128'(0));
  endtask

  logic [OW-1:0] m3;
  bit hi;

  initial begin
    rst = 1'b1; in_valid = 1'b0; opt = 1'b0; in_data = '0;
    o_out = '0; o_len = '0; o_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_out", 128'(dout), 128'(0));
    chk("rst_len", 128'(out_len), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    tq = '{5'd16, 5'd3, 5'd18, 5'd4, 5'd5};
    do_job(0, 0, "p_add_mul");
    chk("p_add_mul_val", 128'(o_out), 128'(23));
    chk("p_add_mul_cyc", 128'(m_lat), 128'(6));

    tq = '{5'd19, 5'd17, 5'd2, 5'd9, 5'd2};
    do_job(0, 0, "p_div_neg");
    m3 = '1; m3[1] = 1'b0;
    chk("p_div_neg_val", 128'(o_out), 128'(m3));

    tq = '{5'd19, 5'd5, 5'd0};
    do_job(0, 0, "p_div0");
    chk("p_div0_err", 128'(o_err), 128'(1));

    tq = '{5'd3, 5'd16, 5'd4, 5'd18, 5'd5};
    do_job(1, 0, "i_prec");
    chk("i_prec_val", 128'(o_out), 128'({5'd3, 5'd4, 5'd5, 5'd18, 5'd16, 70'd0}));
    chk("i_prec_len", 128'(o_len), 128'(5));

    tq = '{5'd20, 5'd1, 5'd16, 5'd2, 5'd21, 5'd18, 5'd3};
    do_job(1, 0, "i_paren");
    chk("i_paren_val", 128'(o_out), 128'({5'd1, 5'd2, 5'd16, 5'd3, 5'd18, 70'd0}));

    tq = '{5'd1, 5'd21};
    do_job(1, 0, "i_unmatched");
    chk("i_unmatched_err", 128'(o_err), 128'(1));

    tq = '{5'd7};
    do_job(0, 0, "p_single");
    tq = '{5'd7};
    do_job(1, 0, "i_single");

    gen_prefix(9);
    tq.push_back(5'd1);
    tq.push_back(5'd2);
    do_job(0, 1, "p_ovf");
    chk("p_ovf_err", 128'(o_err), 128'(1));

    gen_prefix(5);
    do_job(0, 1, "p_toggle");

    // Reset in the middle of EVAL must cancel the job.
    gen_prefix(6);
    foreach (tq[i]) begin
      in_valid = 1'b1; in_data = tq[i]; opt = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    hi = 0;
    repeat (25) begin
      if (out_valid) hi = 1;
      @(posedge clk); #1;
    end
    chk("rst_mid_quiet", 128'(hi), 128'(0));
    tq = '{5'd16, 5'd1, 5'd2};
    do_job(0, 0, "p_after_rst");
    chk("p_after_rst_val", 128'(o_out), 128'(3));

    for (int j = 0; j < 40; j++) begin
      gen_prefix($urandom_range(9, 0));
      do_job(0, j[0], "rnd_p");
    end
    for (int j = 0; j < 40; j++) begin
      gen_infix();
      do_job(1, 0, "rnd_i");
    end
    for (int j = 0; j < 20; j++) begin
      gen_junk();
      do_job(j[0], 0, "rnd_junk");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
